// File: rtl/adder_seq_cla.sv
// ============================================================================
// adder_seq_cla -- multi-cycle WIDTH-bit adder built around one 8-bit
// carry-lookahead slice.
//
// The operands are captured on acceptance and added one byte per cycle,
// least significant byte first. The carry out of each byte is carried
// forward into the next cycle. This trades latency for area: one adder_cla_8b
// is shared across all byte positions.
//
// Optional feature (macro ADDER_SEQ_SUB_EN):
//   Adds port i_sub. When i_sub=1 at acceptance, B is inverted and the
//   slice-0 carry-in is forced to 1, so the result is A-B mod 2^WIDTH.
//   o_c_out=1 then means "no borrow" (A >= B). Without the macro the block
//   only adds and has no i_sub port.
//
// Ports:
//   i_clk    in   1      clock, rising edge
//   i_rst    in   1      synchronous active-high reset
//   i_valid  in   1      operand request valid
//   o_ready  out  1      block can accept a request (IDLE only)
//   i_a      in   WIDTH  operand A
//   i_b      in   WIDTH  operand B
//   i_c_in   in   1      carry into bit 0
//   i_sub    in   1      subtract select (only with ADDER_SEQ_SUB_EN)
//   o_valid  out  1      result valid (DONE only)
//   i_ready  in   1      downstream accepts the result
//   o_sum    out  WIDTH  (A + B + c_in) mod 2^WIDTH
//   o_c_out  out  1      carry out of bit WIDTH-1
//   o_zero   out  1      o_sum == 0
// ============================================================================

// ----------------------------------------------------------------------------
// adder_cla_8b -- 8-bit carry-lookahead slice.
// Ports: i_a/i_b (8) operands, i_c_in carry in, o_sum (8) sum,
// o_c_out carry out, o_p/o_g group propagate/generate.
// ----------------------------------------------------------------------------
module adder_cla_8b (
   input  logic [7:0] i_a,
   input  logic [7:0] i_b,
   input  logic       i_c_in,
   output logic [7:0] o_sum,
   output logic       o_c_out,
   output logic       o_p,
   output logic       o_g
);

   logic [7:0] bit_p;
   logic [7:0] bit_g;
   logic [8:0] carry;
   logic       group_g;

   // Per-bit propagate/generate, then the lookahead carries. The group
   // generate is folded with c_in=0 so the group carry out is simply
   // G | (P & c_in), the form an upstream lookahead level would consume.
   always_comb begin
      bit_p    = i_a ^ i_b;
      bit_g    = i_a & i_b;
      carry    = '0;
      carry[0] = i_c_in;
      group_g  = 1'b0;
      for (int i = 0; i < 8; i++) begin
         carry[i+1] = bit_g[i] | (bit_p[i] & carry[i]);
         group_g    = bit_g[i] | (bit_p[i] & group_g);
      end
      o_sum   = bit_p ^ carry[7:0];
      o_p     = &bit_p;
      o_g     = group_g;
      o_c_out = group_g | (o_p & i_c_in);
   end

endmodule

module adder_seq_cla #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_c_in,
`ifdef ADDER_SEQ_SUB_EN
   input  logic             i_sub,
`endif
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_c_out,
   output logic             o_zero
);

   localparam int NSLICE = WIDTH / 8;
   localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   // Reject widths the byte-serial datapath cannot cover exactly.
   if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_bad_width
      $error("adder_seq_cla: WIDTH must be a multiple of 8 and at least 8");
   end

   typedef enum logic [1:0] {
      IDLE,
      ADD,
      DONE
   } state_t;

   state_t             state;
   state_t             next_state;

   logic [WIDTH-1:0]   a_reg;
   logic [WIDTH-1:0]   b_reg;
   logic [WIDTH-1:0]   acc_reg;
   logic [WIDTH-1:0]   acc_next;
   logic               carry_reg;
   logic [IDX_W-1:0]   idx;
   logic               last_slice;

   logic [WIDTH-1:0]   sum_reg;
   logic               c_out_reg;
   logic               zero_reg;

   logic [7:0]         slice_a;
   logic [7:0]         slice_b;
   logic [7:0]         slice_sum;
   logic               slice_c_out;

   // The single shared slice always works on byte 'idx' of the captured
   // operands with the carry left over from the previous byte.
   assign slice_a    = a_reg[8*idx +: 8];
   assign slice_b    = b_reg[8*idx +: 8];
   assign last_slice = (idx == IDX_W'(NSLICE - 1));

   adder_cla_8b u_slice (
      .i_a     (slice_a),
      .i_b     (slice_b),
      .i_c_in  (carry_reg),
      .o_sum   (slice_sum),
      .o_c_out (slice_c_out),
      .o_p     (),
      .o_g     ()
   );

   // Partial sum with the current byte merged in. On the last slice this is
   // the complete result, so the zero flag is taken from it directly rather
   // than waiting a cycle for the accumulator to settle.
   always_comb begin
      acc_next               = acc_reg;
      acc_next[8*idx +: 8]   = slice_sum;
   end

   // State register; reset wins over everything, discarding any in-flight add.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and handshake outputs. DONE returns to IDLE rather than
   // re-accepting directly, so o_ready only rises the cycle after the result
   // is taken.
   always_comb begin
      next_state = state;
      o_ready    = 1'b0;
      o_valid    = 1'b0;
      case (state)
         IDLE: begin
            o_ready = 1'b1;
            if (i_valid) begin
               next_state = ADD;
            end
         end
         ADD: begin
            if (last_slice) begin
               next_state = DONE;
            end
         end
         DONE: begin
            o_valid = 1'b1;
            if (i_ready) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Datapath. The visible result registers are written only when the last
   // byte completes, so o_sum/o_c_out/o_zero keep the previous result through
   // IDLE and ADD instead of showing partial sums.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         a_reg     <= '0;
         b_reg     <= '0;
         acc_reg   <= '0;
         carry_reg <= 1'b0;
         idx       <= '0;
         sum_reg   <= '0;
         c_out_reg <= 1'b0;
         zero_reg  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_valid) begin
                  a_reg   <= i_a;
                  acc_reg <= '0;
                  idx     <= '0;
`ifdef ADDER_SEQ_SUB_EN
                  b_reg     <= i_sub ? ~i_b : i_b;
                  carry_reg <= i_sub ? 1'b1 : i_c_in;
`else
                  b_reg     <= i_b;
                  carry_reg <= i_c_in;
`endif
               end
            end
            ADD: begin
               acc_reg   <= acc_next;
               carry_reg <= slice_c_out;
               idx       <= idx + 1'b1;
               if (last_slice) begin
                  sum_reg   <= acc_next;
                  c_out_reg <= slice_c_out;
                  zero_reg  <= (acc_next == '0);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign o_sum   = sum_reg;
   assign o_c_out = c_out_reg;
   assign o_zero  = zero_reg;

endmodule

// File: tb/tb_adder_seq_cla.sv
// ============================================================================
// tb_adder_seq_cla -- self-checking bench for adder_seq_cla.
// A 32-bit instance carries most scenarios; an 8-bit instance covers the
// single-slice case. Expected results are queued when a request is driven
// and popped when the DUT raises o_valid.
// ============================================================================
module tb_adder_seq_cla;

   typedef struct packed {
      logic [31:0] sum;
      logic        c_out;
      logic        zero;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        in_valid = 1'b0;
   logic        out_ready;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        c_in = 1'b0;
   logic        sub = 1'b0;
   logic        out_valid;
   logic        ds_ready = 1'b0;
   logic [31:0] sum;
   logic        c_out;
   logic        zero;

   logic        in_valid8 = 1'b0;
   logic        ready8;
   logic [7:0]  a8 = '0;
   logic [7:0]  b8 = '0;
   logic        c_in8 = 1'b0;
   logic        valid8;
   logic        ds_ready8 = 1'b0;
   logic [7:0]  sum8;
   logic        c_out8;
   logic        zero8;

   exp_t        sb[$];
   exp_t        sb8[$];
   int          n_vec = 0;
   int          n_bad = 0;

   // 10 ns clock shared by both instances.
   always #5 clk = ~clk;

   adder_seq_cla #(.WIDTH(32)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_valid (in_valid),
      .o_ready (out_ready),
      .i_a     (a),
      .i_b     (b),
      .i_c_in  (c_in),
`ifdef ADDER_SEQ_SUB_EN
      .i_sub   (sub),
`endif
      .o_valid (out_valid),
      .i_ready (ds_ready),
      .o_sum   (sum),
      .o_c_out (c_out),
      .o_zero  (zero)
   );

   adder_seq_cla #(.WIDTH(8)) dut8 (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_valid (in_valid8),
      .o_ready (ready8),
      .i_a     (a8),
      .i_b     (b8),
      .i_c_in  (c_in8),
`ifdef ADDER_SEQ_SUB_EN
      .i_sub   (1'b0),
`endif
      .o_valid (valid8),
      .i_ready (ds_ready8),
      .o_sum   (sum8),
      .o_c_out (c_out8),
      .o_zero  (zero8)
   );

   // Reference model: 33-bit addition of A, (optionally inverted) B and carry.
   function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv,
                                  input logic cv, input logic sv);
      logic [32:0] t;
      logic [31:0] bb;
      logic        ci;
      exp_t        e;
      bb = sv ? ~bv : bv;
      ci = sv ? 1'b1 : cv;
      t  = {1'b0, av} + {1'b0, bb} + {32'd0, ci};
      e.sum   = t[31:0];
      e.c_out = t[32];
      e.zero  = (t[31:0] == 32'd0);
      return e;
   endfunction

   // Present a request and hold it until the accepting edge has passed.
   task automatic send(input logic [31:0] av, input logic [31:0] bv,
                       input logic cv, input logic sv);
      logic ok;
      ok = 1'b0;
      a = av; b = bv; c_in = cv; sub = sv; in_valid = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (out_ready === 1'b1) ok = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!ok) begin
         n_vec++; n_bad++;
         $display("[TB] FAIL accept_timeout: got o_ready=%b required 1 within 20 cycles", out_ready);
      end
   endtask

   // Wait for o_valid, counting edges since acceptance.
   task automatic wait_result(output int lat);
      logic got;
      got = 1'b0;
      lat = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         if (out_valid === 1'b1) got = 1'b1;
         else begin
            @(posedge clk); #1; lat++;
         end
      end
      if (!got) begin
         n_vec++; n_bad++;
         $display("[TB] FAIL result_timeout: got o_valid=%b required 1 within 40 cycles", out_valid);
      end
   endtask

   task automatic release_result();
      ds_ready = 1'b1;
      @(posedge clk); #1;
      ds_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; ds_ready = 1'b0; in_valid8 = 1'b0;
      repeat (2) @(posedge clk);
      #1; rst = 1'b0;
      n_vec++; if (out_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_ready: got %b required 1", out_ready); end
      n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_valid: got %b required 0", out_valid); end
      n_vec++; if (sum !== 32'd0) begin n_bad++; $display("[TB] FAIL reset_sum: got %h required 0", sum); end
      n_vec++; if (c_out !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_cout: got %b required 0", c_out); end
      n_vec++; if (zero !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_zero: got %b required 0", zero); end
      n_vec++; if (ready8 !== 1'b1 || valid8 !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_w8: got ready=%b valid=%b required 1/0", ready8, valid8); end
   endtask

   task automatic test_carry_ripple();
      exp_t e;
      int   lat;
      sb.push_back(model(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0));
      send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      wait_result(lat);
      e = sb.pop_front();
      n_vec++; if (lat != 4) begin n_bad++; $display("[TB] FAIL ripple_latency: got %0d required 4", lat); end
      n_vec++; if (sum !== e.sum) begin n_bad++; $display("[TB] FAIL ripple_sum: got %h required %h", sum, e.sum); end
      n_vec++; if (c_out !== e.c_out) begin n_bad++; $display("[TB] FAIL ripple_cout: got %b required %b", c_out, e.c_out); end
      n_vec++; if (zero !== e.zero) begin n_bad++; $display("[TB] FAIL ripple_zero: got %b required %b", zero, e.zero); end
      n_vec++; if (out_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL done_ready: got %b required 0", out_ready); end
      release_result();
      n_vec++; if (out_valid !== 1'b0 || out_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL ripple_release: got valid=%b ready=%b required 0/1", out_valid, out_ready); end
   endtask

   task automatic test_mixed();
      exp_t e;
      int   lat;
      sb.push_back(model(32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0));
      send(32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0);
      // Operand changes and a stray request during ADD must be ignored.
      a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D; c_in = 1'b0; in_valid = 1'b1;
      n_vec++; if (out_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL add_ready: got %b required 0", out_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_result(lat);
      e = sb.pop_front();
      n_vec++; if (lat != 3) begin n_bad++; $display("[TB] FAIL mixed_latency: got %0d required 3 after extra cycle", lat); end
      n_vec++; if (sum !== e.sum) begin n_bad++; $display("[TB] FAIL mixed_sum: got %h required %h", sum, e.sum); end
      n_vec++; if (c_out !== e.c_out || zero !== e.zero) begin n_bad++; $display("[TB] FAIL mixed_flags: got c=%b z=%b required c=%b z=%b", c_out, zero, e.c_out, e.zero); end
      release_result();
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   lat;
      logic [31:0] na, nb;
      sb.push_back(model(32'hA000_1234, 32'h0000_5678, 1'b0, 1'b0));
      send(32'hA000_1234, 32'h0000_5678, 1'b0, 1'b0);
      wait_result(lat);
      e = sb.pop_front();
      // Hold the result under backpressure while requests are pulsed at it.
      for (int i = 0; i < 10; i++) begin
         in_valid = i[0]; a = $urandom; b = $urandom;
         n_vec++; if (out_valid !== 1'b1 || out_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL hold_hs[%0d]: got valid=%b ready=%b required 1/0", i, out_valid, out_ready); end
         n_vec++; if (sum !== e.sum || c_out !== e.c_out) begin n_bad++; $display("[TB] FAIL hold_sum[%0d]: got %h/%b required %h/%b", i, sum, c_out, e.sum, e.c_out); end
         @(posedge clk); #1;
      end
      na = 32'h7FFF_FFFF; nb = 32'h8000_0001;
      a = na; b = nb; c_in = 1'b0; in_valid = 1'b1; ds_ready = 1'b1;
      sb.push_back(model(na, nb, 1'b0, 1'b0));
      @(posedge clk); #1;
      ds_ready = 1'b0;
      n_vec++; if (out_ready !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL b2b_idle: got ready=%b valid=%b required 1/0", out_ready, out_valid); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_result(lat);
      e = sb.pop_front();
      n_vec++; if (lat != 4) begin n_bad++; $display("[TB] FAIL b2b_latency: got %0d required 4", lat); end
      n_vec++; if (sum !== e.sum || c_out !== e.c_out || zero !== e.zero) begin n_bad++; $display("[TB] FAIL b2b_result: got %h/%b/%b required %h/%b/%b", sum, c_out, zero, e.sum, e.c_out, e.zero); end
      release_result();
   endtask

   task automatic test_reset_mid_add();
      logic seen;
      send(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_vec++; if (out_ready !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_hs: got ready=%b valid=%b required 1/0", out_ready, out_valid); end
      n_vec++; if (sum !== 32'd0 || c_out !== 1'b0 || zero !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_result: got %h/%b/%b required 0/0/0", sum, c_out, zero); end
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid !== 1'b0) seen = 1'b1;
         @(posedge clk); #1;
      end
      n_vec++; if (seen) begin n_bad++; $display("[TB] FAIL midrst_novalid: got o_valid=1 required no result"); end
   endtask

   task automatic test_random();
      exp_t e;
      int   lat;
      logic [31:0] ra, rb;
      logic        rc;
      for (int i = 0; i < 8; i++) begin
         ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
         if (i == 0) begin ra = 32'hFFFF_FFFF; rb = 32'h0; rc = 1'b1; end
         sb.push_back(model(ra, rb, rc, 1'b0));
         send(ra, rb, rc, 1'b0);
         wait_result(lat);
         e = sb.pop_front();
         n_vec++; if (sum !== e.sum || c_out !== e.c_out || zero !== e.zero) begin n_bad++; $display("[TB] FAIL rand[%0d]: got %h/%b/%b required %h/%b/%b", i, sum, c_out, zero, e.sum, e.c_out, e.zero); end
         release_result();
      end
   endtask

`ifdef ADDER_SEQ_SUB_EN
   task automatic test_sub();
      exp_t e;
      int   lat;
      sb.push_back(model(32'd5, 32'd7, 1'b0, 1'b1));
      send(32'd5, 32'd7, 1'b0, 1'b1);
      wait_result(lat);
      e = sb.pop_front();
      n_vec++; if (sum !== 32'hFFFF_FFFE || c_out !== 1'b0 || sum !== e.sum) begin n_bad++; $display("[TB] FAIL sub_5_7: got %h/%b required fffffffe/0", sum, c_out); end
      release_result();
      sb.push_back(model(32'd7, 32'd5, 1'b0, 1'b1));
      send(32'd7, 32'd5, 1'b0, 1'b1);
      wait_result(lat);
      e = sb.pop_front();
      n_vec++; if (sum !== 32'd2 || c_out !== 1'b1 || lat != 4 || sum !== e.sum) begin n_bad++; $display("[TB] FAIL sub_7_5: got %h/%b lat %0d required 00000002/1 lat 4", sum, c_out, lat); end
      release_result();
   endtask
`endif

   task automatic test_width8();
      exp_t e;
      int   lat;
      logic got;
      logic [7:0] va [2];
      logic [7:0] vb [2];
      logic       vc [2];
      logic [8:0] t;
      va[0] = 8'h80; vb[0] = 8'h80; vc[0] = 1'b0;
      va[1] = 8'h3C; vb[1] = 8'h41; vc[1] = 1'b1;
      for (int k = 0; k < 2; k++) begin
         t = {1'b0, va[k]} + {1'b0, vb[k]} + {8'd0, vc[k]};
         e.sum = {24'd0, t[7:0]}; e.c_out = t[8]; e.zero = (t[7:0] == 8'd0);
         sb8.push_back(e);
         a8 = va[k]; b8 = vb[k]; c_in8 = vc[k]; in_valid8 = 1'b1;
         n_vec++; if (ready8 !== 1'b1) begin n_bad++; $display("[TB] FAIL w8_ready[%0d]: got %b required 1", k, ready8); end
         @(posedge clk); #1;
         in_valid8 = 1'b0;
         got = 1'b0; lat = 0;
         for (int i = 0; i < 20 && !got; i++) begin
            if (valid8 === 1'b1) got = 1'b1;
            else begin @(posedge clk); #1; lat++; end
         end
         e = sb8.pop_front();
         n_vec++; if (!got || lat != 1) begin n_bad++; $display("[TB] FAIL w8_latency[%0d]: got %0d (valid seen %b) required 1", k, lat, got); end
         n_vec++; if (sum8 !== e.sum[7:0] || c_out8 !== e.c_out || zero8 !== e.zero) begin n_bad++; $display("[TB] FAIL w8_result[%0d]: got %h/%b/%b required %h/%b/%b", k, sum8, c_out8, zero8, e.sum[7:0], e.c_out, e.zero); end
         ds_ready8 = 1'b1;
         @(posedge clk); #1;
         ds_ready8 = 1'b0;
      end
   endtask

   // Scenario sequence; each task does its own comparisons.
   initial begin
      $display("[TB] starting adder_seq_cla bench");
      test_reset();
      test_carry_ripple();
      test_mixed();
      test_back_to_back();
      test_reset_mid_add();
      test_random();
`ifdef ADDER_SEQ_SUB_EN
      test_sub();
`endif
      test_width8();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no completion required finish within 200000 ns");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
